// File: rtl/mojo_serial_pkg.sv
// Constants and width helpers shared by the mojo serial blocks.
package mojo_serial_pkg;

  localparam int BYTE_BITS = 8;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mojo_serial_idle_timer.sv
// Counts idle clocks while run is high; expire is a combinational pulse on the clock the
// count would reach TIMEOUT_CYCLES. clear takes priority and also suppresses expire.
module mojo_serial_idle_timer
  import mojo_serial_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] LAST = ENABLED ? TW'(TIMEOUT_CYCLES - 1) : '0;

  logic [TW-1:0] cnt;

  assign expire = ENABLED && run && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || expire || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/mojo_serial_block_rx.sv
// Packs received bytes into BLOCK_BYTES-wide blocks with one block of output buffering.
// 1-clock latency from final byte to rx_block_valid; a block completing while the output is held is dropped.
module mojo_serial_block_rx
  import mojo_serial_pkg::*;
#(
  parameter int BLOCK_BYTES    = 4,
  parameter bit MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [BYTE_BITS-1:0]                 rx_data,
  input  logic                                 new_rx_data,
  input  logic                                 flush,
  input  logic                                 clear_overflow,
  output logic [BLOCK_BYTES*BYTE_BITS-1:0]     rx_block,
  output logic                                 rx_block_valid,
  input  logic                                 rx_block_ready,
  output logic [count_width(BLOCK_BYTES)-1:0]  fill_count,
  output logic                                 overflow,
  output logic                                 timeout
);

  localparam int BLOCK_BITS = BLOCK_BYTES * BYTE_BITS;
  localparam int CW = count_width(BLOCK_BYTES);

  logic [BLOCK_BITS-1:0] asm_q;
  logic [BLOCK_BITS-1:0] asm_d;
  logic [CW-1:0]         slot;
  int                    slot_lsb;
  logic                  complete;
  logic                  accept;
  logic                  load;
  logic                  drop;
  logic                  filling;
  logic                  expire;

  // A flush in the same cycle as a byte restarts the block, so that byte is byte 0.
  assign slot     = flush ? '0 : fill_count;
  assign complete = new_rx_data && (slot == CW'(BLOCK_BYTES - 1));
  assign accept   = rx_block_valid && rx_block_ready;
  assign load     = complete && (!rx_block_valid || rx_block_ready);
  assign drop     = complete && rx_block_valid && !rx_block_ready;
  assign filling  = (fill_count != '0);

  always_comb begin
    slot_lsb = MSB_FIRST ? (BLOCK_BYTES - 1 - int'(slot)) * BYTE_BITS
                         : int'(slot) * BYTE_BITS;
    asm_d = asm_q;
    if (new_rx_data) begin
      asm_d[slot_lsb +: BYTE_BITS] = rx_data;
    end
  end

  mojo_serial_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (new_rx_data || flush || !filling),
    .run    (filling),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      fill_count <= '0;
      timeout    <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      timeout <= expire;
      if (new_rx_data) begin
        fill_count <= complete ? '0 : slot + CW'(1);
      end else if (flush || expire) begin
        fill_count <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_block       <= '0;
      rx_block_valid <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if (load) begin
        rx_block       <= asm_d;
        rx_block_valid <= 1'b1;
      end else if (accept) begin
        rx_block_valid <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mojo_serial_block_rx.sv
// Two deserializer configurations on shared stimulus, checked every cycle against a byte-queue model.
module tb_mojo_serial_block_rx;

  localparam int BB = 4;
  localparam int P_MSB [2] = '{1, 0};
  localparam int P_TMO [2] = '{10, 0};

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        new_rx_data;
  logic        flush;
  logic        clear_overflow;
  logic        rx_block_ready;

  logic [31:0] blk [2];
  logic        vld [2];
  logic [2:0]  fc  [2];
  logic        ov  [2];
  logic        to  [2];

  int checks;
  int failures;
  bit cmp_en;

  mojo_serial_block_rx #(.BLOCK_BYTES(4), .MSB_FIRST(1), .TIMEOUT_CYCLES(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .flush(flush), .clear_overflow(clear_overflow), .rx_block(blk[0]),
    .rx_block_valid(vld[0]), .rx_block_ready(rx_block_ready), .fill_count(fc[0]),
    .overflow(ov[0]), .timeout(to[0]));

  mojo_serial_block_rx #(.BLOCK_BYTES(4), .MSB_FIRST(0), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .flush(flush), .clear_overflow(clear_overflow), .rx_block(blk[1]),
    .rx_block_valid(vld[1]), .rx_block_ready(rx_block_ready), .fill_count(fc[1]),
    .overflow(ov[1]), .timeout(to[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: partial block as a byte list, idle counter, one-entry output.
  logic [7:0]  m_part [2][BB];
  int          m_cnt  [2];
  int          m_idle [2];
  logic [31:0] m_blk  [2];
  bit          m_vld  [2];
  bit          m_ov   [2];
  bit          m_to   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_idle[i] = 0; m_blk[i] = 0;
        m_vld[i] = 0; m_ov[i] = 0; m_to[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit acc, done, fired;
        logic [31:0] b;
        acc = m_vld[i] && rx_block_ready;
        done = 0; fired = 0; b = 0;
        if (flush) begin
          m_cnt[i] = 0; m_idle[i] = 0;
        end
        if (new_rx_data) begin
          m_part[i][m_cnt[i]] = rx_data;
          m_cnt[i]++;
          m_idle[i] = 0;
          if (m_cnt[i] == BB) begin
            for (int j = 0; j < BB; j++) begin
              if (P_MSB[i] != 0) b = {b[23:0], m_part[i][j]};
              else b[8*j +: 8] = m_part[i][j];
            end
            m_cnt[i] = 0;
            done = 1;
          end
        end else if (P_TMO[i] > 0 && m_cnt[i] > 0) begin
          m_idle[i]++;
          if (m_idle[i] == P_TMO[i]) begin
            m_cnt[i] = 0; m_idle[i] = 0; fired = 1;
          end
        end
        m_to[i] = fired;
        if (done && m_vld[i] && !acc) m_ov[i] = 1;
        else if (clear_overflow) m_ov[i] = 0;
        if (done && (!m_vld[i] || acc)) begin
          m_blk[i] = b; m_vld[i] = 1;
        end else if (acc) begin
          m_vld[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d] got=%h want=%h at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("rx_block", i, blk[i], m_blk[i]);
        chk("rx_block_valid", i, 32'(vld[i]), 32'(m_vld[i]));
        chk("fill_count", i, 32'(fc[i]), 32'(m_cnt[i]));
        chk("overflow", i, 32'(ov[i]), 32'(m_ov[i]));
        chk("timeout", i, 32'(to[i]), 32'(m_to[i]));
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit f, input bit c, input bit r);
    new_rx_data = v; rx_data = d; flush = f; clear_overflow = c; rx_block_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_block"}, i, blk[i], 32'h0);
      chk({tag, "_valid"}, i, 32'(vld[i]), 32'h0);
      chk({tag, "_fill"}, i, 32'(fc[i]), 32'h0);
      chk({tag, "_ovf"}, i, 32'(ov[i]), 32'h0);
      chk({tag, "_tmo"}, i, 32'(to[i]), 32'h0);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cmp_en = 0;
    rst_n = 1'b0; rx_data = 8'h0; new_rx_data = 0; flush = 0;
    clear_overflow = 0; rx_block_ready = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    cmp_en = 1;

    // Byte order, ready held high: valid for exactly one cycle.
    cyc(1, 8'h11, 0, 0, 1); cyc(1, 8'h22, 0, 0, 1); cyc(1, 8'h33, 0, 0, 1); cyc(1, 8'h44, 0, 0, 1);
    chk("order_msb", 0, blk[0], 32'h11223344);
    chk("order_lsb", 1, blk[1], 32'h44332211);
    chk("order_valid", 0, 32'(vld[0]), 32'h1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("order_valid_drop", 0, 32'(vld[0]), 32'h0);

    // Held output: second block dropped, overflow sticky until cleared.
    for (int k = 1; k <= 8; k++) cyc(1, 8'(k), 0, 0, 0);
    chk("ovf_block", 0, blk[0], 32'h01020304);
    chk("ovf_block", 1, blk[1], 32'h04030201);
    chk("ovf_flag", 0, 32'(ov[0]), 32'h1);
    cyc(0, 8'h00, 0, 1, 0);
    chk("ovf_clear", 0, 32'(ov[0]), 32'h0);
    cyc(0, 8'h00, 0, 0, 1);

    // Accept and load in the same cycle.
    for (int k = 0; k < 4; k++) cyc(1, 8'hA0 + 8'(k), 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 8'hB0 + 8'(k), 0, 0, 0);
    cyc(1, 8'hB3, 0, 0, 1);
    chk("swap_block", 0, blk[0], 32'hB0B1B2B3);
    chk("swap_valid", 0, 32'(vld[0]), 32'h1);
    chk("swap_ovf", 0, 32'(ov[0]), 32'h0);
    cyc(0, 8'h00, 0, 0, 1);

    // Timeout fires 10 clocks after the last byte.
    cyc(1, 8'h51, 0, 0, 1); cyc(1, 8'h52, 0, 0, 1);
    repeat (9) cyc(0, 8'h00, 0, 0, 1);
    chk("tmo_early", 0, 32'(to[0]), 32'h0);
    chk("tmo_early_fill", 0, 32'(fc[0]), 32'h2);
    cyc(0, 8'h00, 0, 0, 1);
    chk("tmo_pulse", 0, 32'(to[0]), 32'h1);
    chk("tmo_fill", 0, 32'(fc[0]), 32'h0);
    chk("tmo_disabled_fill", 1, 32'(fc[1]), 32'h2);
    cyc(0, 8'h00, 0, 0, 1);
    chk("tmo_one_cycle", 0, 32'(to[0]), 32'h0);
    cyc(0, 8'h00, 1, 0, 1);

    // A byte on the expiring clock wins.
    cyc(1, 8'h61, 0, 0, 1); cyc(1, 8'h62, 0, 0, 1);
    repeat (9) cyc(0, 8'h00, 0, 0, 1);
    cyc(1, 8'h63, 0, 0, 1);
    chk("tmo_byte_wins_fill", 0, 32'(fc[0]), 32'h3);
    chk("tmo_byte_wins_pulse", 0, 32'(to[0]), 32'h0);
    cyc(0, 8'h00, 1, 0, 1);

    // Flush with a simultaneous byte.
    cyc(1, 8'h71, 0, 0, 1); cyc(1, 8'h72, 0, 0, 1); cyc(1, 8'h73, 0, 0, 1);
    cyc(1, 8'h74, 1, 0, 1);
    chk("flush_byte_fill", 0, 32'(fc[0]), 32'h1);
    chk("flush_byte_fill", 1, 32'(fc[1]), 32'h1);
    cyc(1, 8'h75, 0, 0, 1); cyc(1, 8'h76, 0, 0, 1); cyc(1, 8'h77, 0, 0, 1);
    chk("flush_block", 0, blk[0], 32'h74757677);

    // Asynchronous reset mid-block, then a clean block.
    cyc(1, 8'h81, 0, 0, 0); cyc(1, 8'h82, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'hC1, 0, 0, 1); cyc(1, 8'hC2, 0, 0, 1); cyc(1, 8'hC3, 0, 0, 1); cyc(1, 8'hC4, 0, 0, 1);
    chk("post_rst_block", 0, blk[0], 32'hC1C2C3C4);
    chk("post_rst_valid", 0, 32'(vld[0]), 32'h1);

    // Randomized phases with varying byte density so timeouts and overflows both occur.
    for (int ph = 0; ph < 20; ph++) begin
      int p_byte, p_rdy;
      p_byte = (ph % 4 == 0) ? 90 : (ph % 4 == 1) ? 60 : (ph % 4 == 2) ? 15 : 4;
      p_rdy  = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 40 : 10;
      for (int k = 0; k < 200; k++) begin
        cyc($urandom_range(99) < p_byte, 8'($urandom), $urandom_range(99) < 3,
            $urandom_range(99) < 5, $urandom_range(99) < p_rdy);
      end
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
